// File: rtl/puzzle_move_unit.sv
// puzzle_move_unit: move executor for the 2x3 sliding-puzzle datapath.
// Reads board/count/order registers, slides the blank one cell, and writes
// back the new board, count+1 and the move appended to the order log.
// Optional feature macro: SOLVED_CHECK_EN (drives 'solved' from a GOAL compare).
module puzzle_move_unit #(
    parameter logic [3:0]  BOARD_REG = 4'd0,
    parameter logic [3:0]  CNT_REG   = 4'd1,
    parameter logic [3:0]  ORD_REG   = 4'd2,
`ifdef SOLVED_CHECK_EN
    parameter logic [17:0] GOAL      = 18'b000101100011010001,
`endif
    parameter int unsigned MAX_MOVES = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic [3:0]  rf_src,
    input  logic [39:0] rf_rdata,
    output logic [3:0]  rf_dst,
    output logic        rf_we,
    output logic [39:0] rf_wdata,
    output logic        done,
    output logic        illegal,
    output logic        solved
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_BOARD, S_RD_CNT, S_RD_ORD, S_CHECK,
        S_WR_BOARD, S_WR_CNT, S_WR_ORD, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dir_q;
    logic [17:0] board_q;
    logic [39:0] cnt_q;
    logic [37:0] ord_q;
    logic [2:0]  blank_q;
    logic        no_blank_q;
    logic        illegal_q;
    logic [17:0] new_board_q;

    logic [2:0]  blank_d;
    logic        blank_found;
    logic        reject;
    logic [2:0]  target;
    logic [2:0]  tgt_val;
    logic [17:0] swapped;

    // Blank search on the board as it is read: lowest cell index holding 0.
    always_comb begin
        blank_d     = '0;
        blank_found = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (!blank_found && rf_rdata[3*i +: 3] == 3'd0) begin
                blank_d     = 3'(i);
                blank_found = 1'b1;
            end
        end
    end

    // Legality of the latched move and the board after swapping blank/target.
    always_comb begin
        reject = no_blank_q || (cnt_q >= 40'(MAX_MOVES));
        target = blank_q;
        unique case (dir_q)
            2'd0: begin reject = reject || (blank_q < 3'd3);  target = blank_q - 3'd3; end
            2'd1: begin reject = reject || (blank_q >= 3'd3); target = blank_q + 3'd3; end
            2'd2: begin reject = reject || (blank_q == 3'd0) || (blank_q == 3'd3); target = blank_q - 3'd1; end
            default: begin reject = reject || (blank_q == 3'd2) || (blank_q == 3'd5); target = blank_q + 3'd1; end
        endcase
        tgt_val = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (target == 3'(i)) tgt_val = board_q[3*i +: 3];
        end
        swapped = board_q;
        for (int unsigned i = 0; i < 6; i++) begin
            if (blank_q == 3'(i))      swapped[3*i +: 3] = tgt_val;
            else if (target == 3'(i))  swapped[3*i +: 3] = 3'd0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Operand capture: each read state latches its register at its closing edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q       <= '0;
            board_q     <= '0;
            cnt_q       <= '0;
            ord_q       <= '0;
            blank_q     <= '0;
            no_blank_q  <= 1'b0;
            illegal_q   <= 1'b0;
            new_board_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE:     if (move_valid) dir_q <= move_dir;
                S_RD_BOARD: begin
                    board_q    <= rf_rdata[17:0];
                    blank_q    <= blank_d;
                    no_blank_q <= ~blank_found;
                end
                S_RD_CNT:   cnt_q <= rf_rdata;
                S_RD_ORD:   ord_q <= rf_rdata[37:0];
                S_CHECK:    begin
                    illegal_q   <= reject;
                    new_board_q <= swapped;
                end
                default: ;
            endcase
        end
    end

    // Next state and Moore outputs decoded from the current state.
    // rf_we is qualified by rst_n so a reset landing in a write state commits nothing.
    always_comb begin
        state_d    = state_q;
        move_ready = 1'b0;
        rf_src     = '0;
        rf_dst     = '0;
        rf_we      = 1'b0;
        rf_wdata   = '0;
        done       = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid) state_d = S_RD_BOARD;
            end
            S_RD_BOARD: begin rf_src = BOARD_REG; state_d = S_RD_CNT; end
            S_RD_CNT:   begin rf_src = CNT_REG;   state_d = S_RD_ORD; end
            S_RD_ORD:   begin rf_src = ORD_REG;   state_d = S_CHECK;  end
            S_CHECK:    state_d = reject ? S_DONE : S_WR_BOARD;
            S_WR_BOARD: begin
                rf_we    = rst_n;
                rf_dst   = BOARD_REG;
                rf_wdata = {22'b0, new_board_q};
                state_d  = S_WR_CNT;
            end
            S_WR_CNT: begin
                rf_we    = rst_n;
                rf_dst   = CNT_REG;
                rf_wdata = cnt_q + 40'd1;
                state_d  = S_WR_ORD;
            end
            S_WR_ORD: begin
                rf_we    = rst_n;
                rf_dst   = ORD_REG;
                rf_wdata = {ord_q, dir_q};
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = illegal_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SOLVED_CHECK_EN
    logic solved_q;

    // Solved flag follows each legal board write; rejected moves leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n)                   solved_q <= 1'b0;
        else if (state_q == S_WR_BOARD) solved_q <= (new_board_q == GOAL);
    end

    assign solved = solved_q;
`else
    assign solved = 1'b0;
`endif

endmodule
